// File: rtl/mpc_trace_arbiter_if.sv
// -----------------------------------------------------------------------------
// mpc_trace_arbiter_if
// Bundles the per-core trace request handshake and the trace RAM write port
// used by mpc_trace_arbiter.
//
//   req_valid  [NUM_CORES]         per-core frame valid
//   req_data   [NUM_CORES*DATA_W]  per-core frames, core i at [i*DATA_W +: DATA_W]
//   req_ready  [NUM_CORES]         per-core accept
//   ram_wr                         RAM write strobe
//   ram_addr   [ADDR_W]            RAM write address
//   ram_wdata  [DATA_W]            RAM write data
//
// modport master : trace sources / RAM side (drives requests)
// modport slave  : the arbiter (accepts requests, drives the RAM port)
// -----------------------------------------------------------------------------
interface mpc_trace_arbiter_if #(
    parameter int NUM_CORES = 5,
    parameter int DATA_W    = 36,
    parameter int ADDR_W    = 10
);
    logic [NUM_CORES-1:0]        req_valid;
    logic [NUM_CORES*DATA_W-1:0] req_data;
    logic [NUM_CORES-1:0]        req_ready;
    logic                        ram_wr;
    logic [ADDR_W-1:0]           ram_addr;
    logic [DATA_W-1:0]           ram_wdata;

    modport master (
        output req_valid, req_data,
        input  req_ready, ram_wr, ram_addr, ram_wdata
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, ram_wr, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mpc_trace_arbiter.sv
// -----------------------------------------------------------------------------
// mpc_trace_arbiter
// Shares one trace RAM between NUM_CORES OCI data-trace sources. Frames are
// round-robin arbitrated, written to sequential RAM addresses one cycle after
// acceptance, and the end-of-test drain is sequenced to assert test_has_ended.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   trace_enable     level, 1 starts/continues capture
//   wrap_mode        1 = circular buffer, 0 = stop when full
//   test_ending      requests the end-of-test drain
//   test_has_ended   sticky, trace complete (DONE reached)
//   wrap_flag        sticky, write address has wrapped at least once
//   drop_count[16]   frames discarded in DONE, saturating
//   bus              mpc_trace_arbiter_if.slave (requests + RAM write port)
//
// Optional build macro MPC_TRACE_ARB_SRCID_EN: the granted core index is
// stored in the spare frame bits (wdata[DATA_W-1 -: 2] = idx[1:0],
// wdata[DATA_W-3] = idx[2]). Without it the frame is written verbatim.
// -----------------------------------------------------------------------------
module mpc_trace_arbiter #(
    parameter int NUM_CORES = 5,
    parameter int DATA_W    = 36,
    parameter int ADDR_W    = 10,
    parameter int DRAIN_MAX = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trace_enable,
    input  logic        wrap_mode,
    input  logic        test_ending,
    output logic        test_has_ended,
    output logic        wrap_flag,
    output logic [15:0] drop_count,
    mpc_trace_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
    localparam int                CNT_W    = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [2:0]        PTR_LAST = 3'(NUM_CORES - 1);

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [1:0]        state, state_nxt;
    logic [2:0]        rr_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  drain_cnt;

    logic              arb_en;
    logic              gnt_vld;
    logic [2:0]        gnt_idx;
    logic              xfer_p0;
    logic [DATA_W-1:0] frame_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              top_p0;

    logic              vld_p1;
    logic              wrap_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;

    // ---- stage p0: arbitration and acceptance --------------------------------
    assign arb_en = (state == S_RUN) || (state == S_DRAIN);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!gnt_vld && bus.req_valid[(int'(rr_ptr) + k) % NUM_CORES]) begin
                gnt_vld = 1'b1;
                gnt_idx = 3'((int'(rr_ptr) + k) % NUM_CORES);
            end
        end
    end

    assign xfer_p0  = arb_en && gnt_vld;
    assign top_p0   = (wr_addr == ADDR_TOP);
    assign frame_p0 = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];

`ifdef MPC_TRACE_ARB_SRCID_EN
    assign wdata_p0 = {gnt_idx[1:0], gnt_idx[2], frame_p0[DATA_W-4:0]};
`else
    assign wdata_p0 = frame_p0;
`endif

    // DONE accepts everything so that no source can stall forever on a
    // finished trace.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            bus.req_ready[i] = (state == S_DONE) || (xfer_p0 && (gnt_idx == 3'(i)));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (test_ending)       state_nxt = S_DONE;
                else if (trace_enable) state_nxt = S_RUN;
            end
            S_RUN: begin
                // A full buffer in stop mode ends the trace even if a drain
                // request arrives in the same cycle.
                if (xfer_p0 && top_p0 && !wrap_mode) state_nxt = S_DONE;
                else if (test_ending)                state_nxt = S_DRAIN;
                else if (!trace_enable)              state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (!(|bus.req_valid) || (drain_cnt == CNT_LAST)) state_nxt = S_DONE;
            end
            default: state_nxt = S_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            wr_addr    <= '0;
            drain_cnt  <= '0;
            drop_count <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (xfer_p0) begin
                rr_ptr  <= (gnt_idx == PTR_LAST) ? 3'd0 : gnt_idx + 3'd1;
                wr_addr <= wr_addr + 1'b1;
            end
            if (state == S_DONE)
                drop_count <= sat_add16(drop_count, 4'($countones(bus.req_valid)));
        end
    end

    // ---- stage p1: RAM write port --------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            wrap_p1   <= 1'b0;
            addr_p1   <= '0;
            data_p1   <= '0;
            wrap_flag <= 1'b0;
        end else begin
            vld_p1  <= xfer_p0;
            wrap_p1 <= xfer_p0 && top_p0 && wrap_mode;
            if (xfer_p0) begin
                addr_p1 <= wr_addr;
                data_p1 <= wdata_p0;
            end
            // The flag rises once the top-address write has been issued.
            if (vld_p1 && wrap_p1) wrap_flag <= 1'b1;
        end
    end

    assign bus.ram_wr      = vld_p1;
    assign bus.ram_addr    = addr_p1;
    assign bus.ram_wdata   = data_p1;
    assign test_has_ended  = (state == S_DONE);

endmodule

// File: tb/tb_mpc_trace_arbiter.sv
module tb_mpc_trace_arbiter;

    localparam int NC    = 5;
    localparam int DW    = 36;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int DMAX  = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic trace_enable = 1'b0;
    logic wrap_mode = 1'b0;
    logic test_ending = 1'b0;
    logic test_has_ended;
    logic wrap_flag;
    logic [15:0] drop_count;
    logic [DW-1:0] frame [NC];

    mpc_trace_arbiter_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) bus ();

    mpc_trace_arbiter #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .DRAIN_MAX(DMAX)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trace_enable   (trace_enable),
        .wrap_mode      (wrap_mode),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .wrap_flag      (wrap_flag),
        .drop_count     (drop_count),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NC; i++) bus.req_data[i*DW +: DW] = frame[i];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {OFF, CAPTURE, DRAINING, ENDED} mode_t;
    mode_t         m_mode;
    int            m_ptr, m_writes, m_age, m_drop;
    bit            m_flag, m_wr, m_wrap_pend;
    int            m_addr;
    logic [DW-1:0] m_data;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        logic          flag;
    } wrec_t;
    wrec_t wlog [$];

    function automatic logic [DW-1:0] stored(input int g, input logic [DW-1:0] f);
        logic [DW-1:0] d;
        logic [2:0]    gi;
        d  = f;
        gi = 3'(g);
`ifdef MPC_TRACE_ARB_SRCID_EN
        d[DW-1 -: 2] = gi[1:0];
        d[DW-3]      = gi[2];
`endif
        return d;
    endfunction

    // One clock: compare DUT against model at the falling edge, advance the
    // model by the coming rising edge, return 2 time units after it.
    task automatic tick();
        int g;
        logic [NC-1:0] exp_rdy;
        @(negedge clk);
        if (!reset_n) begin
            m_mode = OFF; m_ptr = 0; m_writes = 0; m_age = 0; m_drop = 0;
            m_flag = 0; m_wr = 0; m_wrap_pend = 0; m_addr = 0; m_data = '0;
            chk("rst_ram_wr", bus.ram_wr, 0);
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_ended", test_has_ended, 0);
            chk("rst_flag", wrap_flag, 0);
            chk("rst_drop", drop_count, 0);
        end else begin
            chk("ram_wr", bus.ram_wr, m_wr);
            if (m_wr) begin
                chk("ram_addr", bus.ram_addr, m_addr);
                chk("ram_wdata", bus.ram_wdata, m_data);
            end
            chk("ended", test_has_ended, m_mode == ENDED);
            chk("wrap_flag", wrap_flag, m_flag);
            chk("drop_count", drop_count, m_drop);
            if (bus.ram_wr) wlog.push_back('{int'(bus.ram_addr), bus.ram_wdata, wrap_flag});

            g = -1;
            if (m_mode == CAPTURE || m_mode == DRAINING)
                for (int k = 0; k < NC; k++)
                    if (g < 0 && bus.req_valid[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
            exp_rdy = (m_mode == ENDED) ? '1 : (g >= 0 ? NC'(1 << g) : '0);
            chk("req_ready", bus.req_ready, exp_rdy);

            if (m_wr && m_wrap_pend) m_flag = 1;
            if (g >= 0) begin
                m_wr = 1;
                m_addr = m_writes % DEPTH;
                m_data = stored(g, frame[g]);
                m_wrap_pend = wrap_mode && (m_addr == DEPTH - 1);
                m_writes++;
                m_ptr = (g + 1) % NC;
            end else begin
                m_wr = 0;
                m_wrap_pend = 0;
            end
            if (m_mode == ENDED) begin
                m_drop += $countones(bus.req_valid);
                if (m_drop > 65535) m_drop = 65535;
            end
            case (m_mode)
                OFF:      if (test_ending) m_mode = ENDED;
                          else if (trace_enable) m_mode = CAPTURE;
                CAPTURE:  if (g >= 0 && m_addr == DEPTH - 1 && !wrap_mode) m_mode = ENDED;
                          else if (test_ending) begin m_mode = DRAINING; m_age = 0; end
                          else if (!trace_enable) m_mode = OFF;
                DRAINING: begin
                              m_age++;
                              if (bus.req_valid == 0 || m_age >= DMAX) m_mode = ENDED;
                          end
                default:  m_mode = ENDED;
            endcase
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        trace_enable = 0; wrap_mode = 0; test_ending = 0;
        bus.req_valid = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        wlog.delete();
    endtask

    logic [DW-1:0] rr_exp [6];
    logic [DW-1:0] srcid_exp;
    int n;

    initial begin
        bus.req_valid = '0;
        for (int i = 0; i < NC; i++) frame[i] = '0;
        do_reset();

        // Round-robin: cores 0,2,4 continuously valid
        for (int i = 0; i < NC; i++) frame[i] = DW'(36'h0_0000_00A0 + i);
        trace_enable = 1;
        bus.req_valid = 5'b10101;
        n = 0;
        while (wlog.size() < 6 && n < 30) begin tick(); n++; end
        chk("rr_timeout", wlog.size() >= 6, 1);
        rr_exp = '{36'hA0, 36'hA2, 36'hA4, 36'hA0, 36'hA2, 36'hA4};
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            chk("rr_data", wlog[i].data, rr_exp[i]);
            chk("rr_addr", wlog[i].addr, i);
        end

        // Stop-on-full
        do_reset();
        trace_enable = 1; wrap_mode = 0;
        tick();
        frame[1] = DW'({$urandom, $urandom});
        bus.req_valid = 5'b00010;
        repeat (10) tick();
        bus.req_valid = '0;
        repeat (2) tick();
        chk("full_writes", wlog.size(), 8);
        for (int i = 0; i < wlog.size(); i++) chk("full_addr", wlog[i].addr, i);
        chk("full_ended", test_has_ended, 1);
        chk("full_drop", drop_count, 2);
        chk("full_model_drop", m_drop, 2);

        // Wrap mode
        do_reset();
        trace_enable = 1; wrap_mode = 1;
        tick();
        bus.req_valid = 5'b00010;
        repeat (10) tick();
        bus.req_valid = '0;
        repeat (2) tick();
        chk("wrap_writes", wlog.size(), 10);
        for (int i = 0; i < wlog.size(); i++) chk("wrap_addr", wlog[i].addr, i % DEPTH);
        if (wlog.size() >= 10) begin
            chk("wrap_flag_w8", wlog[7].flag, 0);
            chk("wrap_flag_w9", wlog[8].flag, 1);
        end
        chk("wrap_ended", test_has_ended, 0);
        chk("wrap_flag_end", wrap_flag, 1);

        // Drain ended by an idle cycle
        do_reset();
        trace_enable = 1; wrap_mode = 0;
        tick();
        for (int i = 0; i < NC; i++) frame[i] = DW'({$urandom, $urandom});
        bus.req_valid = 5'b01001;
        repeat (2) tick();
        test_ending = 1;
        tick();
        test_ending = 0;
        repeat (3) tick();
        bus.req_valid = '0;
        chk("drain_not_ended", test_has_ended, 0);
        tick();
        chk("drain_ended", test_has_ended, 1);
        tick();
        chk("drain_writes", wlog.size(), 6);
        if (wlog.size() == 6) chk("drain_last", wlog[5].data, stored(3, frame[3]));

        // Drain ended by the cycle limit
        do_reset();
        trace_enable = 1;
        tick();
        bus.req_valid = 5'b00001;
        tick();
        test_ending = 1;
        tick();
        test_ending = 0;
        n = 0;
        while (!test_has_ended && n < 40) begin tick(); n++; end
        chk("drain_max_cycles", n, DMAX);

        // Reset while a write is on the RAM port
        do_reset();
        trace_enable = 1;
        tick();
        bus.req_valid = 5'b00100;
        n = 0;
        while (!(bus.ram_wr && bus.ram_addr == 3'd5) && n < 30) begin tick(); n++; end
        chk("rst_wait", n < 30, 1);
        reset_n = 0;
        #1;
        chk("rstmid_wr", bus.ram_wr, 0);
        chk("rstmid_addr", bus.ram_addr, 0);
        chk("rstmid_wdata", bus.ram_wdata, 0);
        chk("rstmid_ready", bus.req_ready, 0);
        tick();
        reset_n = 1;
        wlog.delete();
        n = 0;
        while (wlog.size() == 0 && n < 20) begin tick(); n++; end
        chk("rst_first_write_seen", wlog.size() > 0, 1);
        if (wlog.size() > 0) chk("rst_first_addr", wlog[0].addr, 0);

        // Source-id tagging (or verbatim frame when not built in)
        do_reset();
        trace_enable = 1;
        tick();
        frame[4] = 36'h0_1234_5678;
        bus.req_valid = 5'b10000;
        n = 0;
        while (wlog.size() == 0 && n < 20) begin tick(); n++; end
`ifdef MPC_TRACE_ARB_SRCID_EN
        srcid_exp = 36'h2_1234_5678;
`else
        srcid_exp = 36'h0_1234_5678;
`endif
        chk("srcid_seen", wlog.size() > 0, 1);
        if (wlog.size() > 0) chk("srcid_data", wlog[0].data, srcid_exp);

        // Randomized traffic against the model
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            wrap_mode = 1'($urandom_range(0, 1));
            for (int c = 0; c < 400; c++) begin
                trace_enable = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 49) == 0) wrap_mode = ~wrap_mode;
                test_ending = ($urandom_range(0, 199) == 0);
                for (int i = 0; i < NC; i++) begin
                    bus.req_valid[i] = ($urandom_range(0, 3) <= 1 + (seg % 3)) ? 1'b1 : 1'b0;
                    frame[i] = DW'({$urandom, $urandom});
                end
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
